// File: rtl/sram_ctrl_pkg.sv
// Shared defaults, depth and FSM state type for the SRAM port-0 request front-end.
package sram_ctrl_pkg;

   localparam int DEF_ADDR_WIDTH = 9;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_NUM_WMASKS = DEF_DATA_WIDTH / 8;
   localparam int SRAM_DEPTH     = 1 << DEF_ADDR_WIDTH;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } sram_ctrl_state_e;

endpackage

// File: rtl/sram_ctrl_rsp_fifo.sv
// Two-entry in-order response buffer; entry 0 is always the head, entries shift forward on pop.
module sram_ctrl_rsp_fifo
   import sram_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push_i,
   input  logic                  pop_i,
   input  logic [DATA_WIDTH-1:0] din_i,
   output logic [DATA_WIDTH-1:0] dout_o,
   output logic [1:0]            count_o
);

   logic [DATA_WIDTH-1:0] ent0_q, ent0_d;
   logic [DATA_WIDTH-1:0] ent1_q, ent1_d;
   logic [1:0]            cnt_q, cnt_d;
   logic [1:0]            wr_idx;

   // Write slot accounts for the shift caused by a same-cycle pop.
   always_comb begin
      ent0_d = ent0_q;
      ent1_d = ent1_q;
      wr_idx = cnt_q - {1'b0, pop_i};
      if (pop_i) begin
         ent0_d = ent1_q;
      end
      if (push_i) begin
         if (wr_idx == 2'd0) begin
            ent0_d = din_i;
         end else begin
            ent1_d = din_i;
         end
      end
      cnt_d = cnt_q + {1'b0, push_i} - {1'b0, pop_i};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent0_q <= '0;
         ent1_q <= '0;
         cnt_q  <= 2'd0;
      end else begin
         ent0_q <= ent0_d;
         ent1_q <= ent1_d;
         cnt_q  <= cnt_d;
      end
   end

   assign dout_o  = ent0_q;
   assign count_o = cnt_q;

endmodule

// File: rtl/sram_port0_ctrl.sv
// Port-0 request front-end for the 32x512 SRAM macro: valid/ready requests, 1-cycle read capture.
// Optional power-up zero sweep of the whole array when SRAM_CTRL_CLEAR_EN is defined.
module sram_port0_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_WMASKS = DEF_NUM_WMASKS
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [NUM_WMASKS-1:0] req_wmask,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  busy,
   output logic                  sram_clk0,
   output logic                  sram_csb0,
   output logic                  sram_web0,
   output logic [NUM_WMASKS-1:0] sram_wmask0,
   output logic [ADDR_WIDTH-1:0] sram_addr0,
   output logic [DATA_WIDTH-1:0] sram_din0,
   input  logic [DATA_WIDTH-1:0] sram_dout0
);

   sram_ctrl_state_e state_q, state_d;
   logic             rd_pend_q, rd_pend_d;
   logic             accept;
   logic             rsp_pop;
   logic [1:0]       rsp_count;
   logic [2:0]       occupancy;
`ifdef SRAM_CTRL_CLEAR_EN
   logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
   localparam sram_ctrl_state_e RESET_STATE = CLEAR;
`else
   localparam sram_ctrl_state_e RESET_STATE = RUN;
`endif

   // Combinational rsp_ready -> req_ready path lets a popping cycle accept a new read.
   assign rsp_pop   = rsp_valid & rsp_ready;
   assign occupancy = {2'b00, rd_pend_q} + {1'b0, rsp_count} - {2'b00, rsp_pop};
   assign req_ready = rst_n && (state_q == RUN) && (occupancy < 3'd2);
   assign accept    = req_valid & req_ready;

   always_comb begin
      state_d   = state_q;
      rd_pend_d = accept & ~req_we;
`ifdef SRAM_CTRL_CLEAR_EN
      clr_cnt_d = clr_cnt_q;
      if (state_q == CLEAR) begin
         clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
         if (clr_cnt_q == {ADDR_WIDTH{1'b1}}) begin
            state_d = RUN;
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= RESET_STATE;
         rd_pend_q <= 1'b0;
`ifdef SRAM_CTRL_CLEAR_EN
         clr_cnt_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         rd_pend_q <= rd_pend_d;
`ifdef SRAM_CTRL_CLEAR_EN
         clr_cnt_q <= clr_cnt_d;
`endif
      end
   end

   // Pins are forced idle while reset is asserted, independent of the request inputs.
   always_comb begin
      sram_csb0   = 1'b1;
      sram_web0   = 1'b1;
      sram_wmask0 = '0;
      sram_addr0  = '0;
      sram_din0   = '0;
      if (rst_n) begin
`ifdef SRAM_CTRL_CLEAR_EN
         if (state_q == CLEAR) begin
            sram_csb0   = 1'b0;
            sram_web0   = 1'b0;
            sram_wmask0 = '1;
            sram_addr0  = clr_cnt_q;
         end else begin
`else
         begin
`endif
            sram_csb0   = ~accept;
            sram_web0   = ~req_we;
            sram_wmask0 = req_wmask;
            sram_addr0  = req_addr;
            sram_din0   = req_wdata;
         end
      end
   end

   assign sram_clk0 = clk;
`ifdef SRAM_CTRL_CLEAR_EN
   assign busy = (state_q == CLEAR);
`else
   assign busy = 1'b0;
`endif

   // dout0 is only pushed on the cycle after a read issued, so X elsewhere never enters the buffer.
   sram_ctrl_rsp_fifo #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_rsp_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .push_i (rd_pend_q),
      .pop_i  (rsp_pop),
      .din_i  (sram_dout0),
      .dout_o (rsp_rdata),
      .count_o(rsp_count)
   );

   assign rsp_valid = (rsp_count != 2'd0);

endmodule

// File: tb/tb_sram_port0_ctrl.sv
// Scoreboard bench for sram_port0_ctrl with a behavioural SRAM macro and a word-level reference memory.
module tb_sram_port0_ctrl;

   logic        clk;
   logic        rst_n;
   logic        req_valid, req_ready, req_we;
   logic [3:0]  req_wmask;
   logic [8:0]  req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_rdata;
   logic        busy;
   logic        sram_clk0, sram_csb0, sram_web0;
   logic [3:0]  sram_wmask0;
   logic [8:0]  sram_addr0;
   logic [31:0] sram_din0, sram_dout0;

   int nvec = 0;
   int nerr = 0;

   logic [31:0] ref_mem [512];
   logic [31:0] exp_q [$];
   bit          last_rd_acc = 0;

   sram_port0_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_wmask  (req_wmask),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .busy       (busy),
      .sram_clk0  (sram_clk0),
      .sram_csb0  (sram_csb0),
      .sram_web0  (sram_web0),
      .sram_wmask0(sram_wmask0),
      .sram_addr0 (sram_addr0),
      .sram_din0  (sram_din0),
      .sram_dout0 (sram_dout0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] garbage(input int i);
      return (32'(i) * 32'h9E3779B1) ^ 32'hA5A55A5A;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural macro: samples pins at posedge, commits writes and presents read data at negedge.
   logic [31:0] sram_mem [512];
   bit          mem_init = 0;
   logic        m_rd, m_wr;
   logic [8:0]  m_addr;
   logic [31:0] m_din;
   logic [3:0]  m_mask;

   always @(posedge clk) begin
      m_rd   <= !sram_csb0 && sram_web0;
      m_wr   <= !sram_csb0 && !sram_web0;
      m_addr <= sram_addr0;
      m_din  <= sram_din0;
      m_mask <= sram_wmask0;
   end

   always @(negedge clk) begin
      logic [31:0] w;
      if (!mem_init) begin
         for (int i = 0; i < 512; i++) sram_mem[i] <= garbage(i);
         mem_init <= 1'b1;
         sram_dout0 <= $urandom;
      end else begin
         if (m_wr) begin
            w = sram_mem[m_addr];
            for (int b = 0; b < 4; b++) if (m_mask[b]) w[8*b +: 8] = m_din[8*b +: 8];
            sram_mem[m_addr] <= w;
         end
         sram_dout0 <= m_rd ? sram_mem[m_addr] : $urandom;
      end
   end

   // Request tracker: checks req_ready against the outstanding-read count and feeds the scoreboard.
   initial begin
      logic [31:0] w;
      for (int i = 0; i < 512; i++) ref_mem[i] = garbage(i);
      forever begin
         @(negedge clk);
         #3;
         if (!rst_n) begin
            exp_q.delete();
            last_rd_acc = 0;
`ifdef SRAM_CTRL_CLEAR_EN
            for (int i = 0; i < 512; i++) ref_mem[i] = 32'h0;
`endif
         end else begin
            if (busy) chk("req_ready_busy", req_ready, 1'b0);
            else      chk("req_ready", req_ready, exp_q.size() < 2);
            last_rd_acc = req_valid && req_ready && !req_we;
            if (req_valid && req_ready) begin
               if (req_we) begin
                  w = ref_mem[req_addr];
                  for (int b = 0; b < 4; b++) if (req_wmask[b]) w[8*b +: 8] = req_wdata[8*b +: 8];
                  ref_mem[req_addr] = w;
               end else begin
                  exp_q.push_back(ref_mem[req_addr]);
               end
            end
         end
      end
   end

   // Response monitor: a read issued before the last posedge must already be visible.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (rst_n) begin
            chk("rsp_valid", rsp_valid, (exp_q.size() - int'(last_rd_acc)) > 0);
            if (rsp_valid && rsp_ready) begin
               if (exp_q.size() == 0) begin
                  nvec++;
                  nerr++;
                  $display("FAIL rsp_unexpected: got %0h required no response", rsp_rdata);
               end else begin
                  chk("rsp_rdata", rsp_rdata, exp_q.pop_front());
               end
            end
         end
      end
   end

   task automatic idle(input int n);
      req_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input bit we, input logic [8:0] a, input logic [31:0] d, input logic [3:0] m);
      bit done;
      done      = 0;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      req_wmask = m;
      for (int k = 0; k < 20 && !done; k++) begin
         #4;
         done = req_ready;
         @(negedge clk);
      end
      if (!done) begin
         nvec++;
         nerr++;
         $display("FAIL send_timeout: req_ready stayed 0, required acceptance of addr %0d", a);
      end
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = 1'b1;
      req_we    = 1'($urandom);
      req_addr  = 9'($urandom);
      req_wdata = $urandom;
      req_wmask = 4'($urandom);
      rsp_ready = 1'b1;
      #1;
      chk("reset_outputs",
          {req_ready, rsp_valid, rsp_rdata, sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0},
          {1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'h0, 9'h0, 32'h0});
      chk("sram_clk0", sram_clk0, clk);
`ifdef SRAM_CTRL_CLEAR_EN
      chk("reset_busy", busy, 1'b1);
`else
      chk("reset_busy", busy, 1'b0);
`endif
      repeat (2) @(negedge clk);
      rst_n     = 1'b1;
      req_valid = 1'b0;
`ifdef SRAM_CTRL_CLEAR_EN
      for (int i = 0; i < 512; i++) begin
         #1;
         chk("sweep_pins", {busy, sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0},
             {1'b1, 1'b0, 1'b0, 4'hF, 9'(i), 32'h0});
         @(negedge clk);
      end
      #1;
      chk("sweep_done_busy", busy, 1'b0);
`endif
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_wmask = 4'h0;
      req_addr  = 9'h0;
      req_wdata = 32'h0;
      rsp_ready = 1'b0;
      @(negedge clk);
      do_reset();
      rsp_ready = 1'b1;

      send(1'b1, 9'd5, 32'hDEADBEEF, 4'hF);
      send(1'b0, 9'd5, 32'h0, 4'h0);
      idle(3);

      send(1'b1, 9'd7, 32'hFFFFFFFF, 4'hF);
      send(1'b1, 9'd7, 32'h00000012, 4'b0001);
      send(1'b0, 9'd7, 32'h0, 4'h0);
      idle(3);

      send(1'b0, 9'd0, 32'h0, 4'h0);
      send(1'b0, 9'd511, 32'h0, 4'h0);
      idle(3);

      for (int i = 0; i < 8; i++) send(1'b0, 9'(16 + i), 32'h0, 4'h0);
      idle(3);

      rsp_ready = 1'b0;
      send(1'b0, 9'd5, 32'h0, 4'h0);
      send(1'b0, 9'd7, 32'h0, 4'h0);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 9'd0;
      #4 chk("bp_ready_low0", req_ready, 1'b0);
      @(negedge clk);
      #4 chk("bp_ready_low1", req_ready, 1'b0);
      @(negedge clk);
      rsp_ready = 1'b1;
      #4 chk("bp_ready_raise", req_ready, 1'b1);
      @(negedge clk);
      rsp_ready = 1'b0;
      idle(2);
      rsp_ready = 1'b1;
      idle(4);

      for (int i = 0; i < 400; i++) begin
         rsp_ready = ($urandom_range(0, 3) != 0);
         req_valid = ($urandom_range(0, 2) != 0);
         req_we    = 1'($urandom_range(0, 1));
         req_addr  = 9'($urandom_range(0, 15));
         req_wdata = $urandom;
         req_wmask = 4'($urandom_range(0, 15));
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      idle(1);
      for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
      chk("drain_empty", exp_q.size(), 0);

      send(1'b0, 9'd3, 32'h0, 4'h0);
      do_reset();
      rsp_ready = 1'b1;
      idle(5);

      send(1'b0, 9'd5, 32'h0, 4'h0);
      send(1'b0, 9'd511, 32'h0, 4'h0);
      idle(4);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
